// File: rtl/power_seq_pkg.sv
// Shared types, defaults and sizing helper for the power sequencing controller.
package power_seq_pkg;

  typedef enum logic [1:0] {
    StOff       = 2'd0,
    StArming    = 2'd1,
    StOn        = 2'd2,
    StDisarming = 2'd3
  } pwr_state_e;

  localparam int unsigned HOLD_MS_DEF     = 1000;
  localparam int unsigned OFF_HOLD_MS_DEF = 1;
  localparam int unsigned IDLE_MS_DEF     = 10000;
  localparam int unsigned WARN_MS_DEF     = 3000;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic logic is_live(pwr_state_e s);
    return (s == StOn) || (s == StDisarming);
  endfunction

endpackage

// File: rtl/power_seq_ctrl_if.sv
// Button/status bundle between the button-sync layer and the power sequencer.
interface power_seq_ctrl_if;
  logic       on_btn;
  logic       off_btn;
  logic       activity;
  logic       power;
  logic [1:0] state;
  logic       arm_busy;
  logic       idle_warn;
  logic       timeout_pulse;

  modport master (
    output on_btn, off_btn, activity,
    input  power, state, arm_busy, idle_warn, timeout_pulse
  );

  modport slave (
    input  on_btn, off_btn, activity,
    output power, state, arm_busy, idle_warn, timeout_pulse
  );
endinterface

// File: rtl/hold_timer.sv
// Saturating consecutive-sample counter; done is high on the N-th consecutive
// high sample, after which the count restarts from 0.
module hold_timer #(
  parameter int unsigned N     = 1,
  parameter int unsigned CNT_W = 14
) (
  input  logic clk_ms,
  input  logic rst,
  input  logic sample,
  input  logic clear,
  output logic done
);

  localparam logic [CNT_W-1:0] Last = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = sample && !clear && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !sample || done) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ms or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/power_seq_ctrl.sv
// Hold-to-arm / hold-to-release power sequencer with re-arm lockout.
// Optional inactivity auto-shutdown enabled by defining POWER_SEQ_AUTO_OFF_EN.
module power_seq_ctrl
  import power_seq_pkg::*;
#(
  parameter int unsigned HOLD_MS     = HOLD_MS_DEF,
  parameter int unsigned OFF_HOLD_MS = OFF_HOLD_MS_DEF,
  parameter int unsigned IDLE_MS     = IDLE_MS_DEF,
  parameter int unsigned WARN_MS     = WARN_MS_DEF,
  parameter int unsigned CNT_W       = cnt_width(IDLE_MS_DEF)
) (
  input logic              clk_ms,
  input logic              rst,
  power_seq_ctrl_if.slave  bus
);

  pwr_state_e state_q, state_d;
  logic       lockout_q, lockout_d;
  logic       power_q;
  logic       on_done, off_done;
  logic       arm_ok;
  logic       auto_off;

  // On-hold counting only runs where a press may legally progress towards ON.
  assign arm_ok = ((state_q == StOff) && !lockout_q) || (state_q == StArming);

  hold_timer #(
    .N     (HOLD_MS),
    .CNT_W (CNT_W)
  ) u_on_timer (
    .clk_ms (clk_ms),
    .rst    (rst),
    .sample (bus.on_btn),
    .clear  (!arm_ok || bus.off_btn),
    .done   (on_done)
  );

  hold_timer #(
    .N     (OFF_HOLD_MS),
    .CNT_W (CNT_W)
  ) u_off_timer (
    .clk_ms (clk_ms),
    .rst    (rst),
    .sample (bus.off_btn),
    .clear  (!is_live(state_q)),
    .done   (off_done)
  );

`ifdef POWER_SEQ_AUTO_OFF_EN
  localparam logic [CNT_W-1:0] IdleLast  = CNT_W'(IDLE_MS - 1);
  localparam logic [CNT_W-1:0] WarnStart = CNT_W'(IDLE_MS - WARN_MS);

  logic [CNT_W-1:0] idle_q, idle_d;
  logic             quiet;
  logic             timeout_q;

  assign quiet    = !bus.activity && !bus.on_btn && !bus.off_btn;
  assign auto_off = is_live(state_q) && quiet && (idle_q == IdleLast);

  always_comb begin
    idle_d = '0;
    if (is_live(state_d) && quiet) begin
      idle_d = (idle_q != '1) ? idle_q + 1'b1 : idle_q;
    end
  end

  always_ff @(posedge clk_ms or negedge rst) begin
    if (!rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= auto_off;
    end
  end

  assign bus.idle_warn     = (idle_q >= WarnStart);
  assign bus.timeout_pulse = timeout_q;
`else
  localparam int unsigned unused_idle_cfg = IDLE_MS + WARN_MS;
  logic unused_activity;

  assign unused_activity   = bus.activity;
  assign auto_off          = 1'b0;
  assign bus.idle_warn     = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  // Priority inside live states: off_btn, then auto-off; on_btn is ignored.
  always_comb begin
    state_d   = state_q;
    lockout_d = lockout_q;
    unique case (state_q)
      StOff: begin
        if (!bus.on_btn) begin
          lockout_d = 1'b0;
        end else if (!lockout_q && !bus.off_btn) begin
          if (on_done) begin
            state_d   = StOn;
            lockout_d = 1'b1;
          end else begin
            state_d = StArming;
          end
        end
      end
      StArming: begin
        if (!bus.on_btn || bus.off_btn) begin
          state_d = StOff;
        end else if (on_done) begin
          state_d   = StOn;
          lockout_d = 1'b1;
        end
      end
      StOn, StDisarming: begin
        if (bus.off_btn) begin
          if (off_done) begin
            state_d   = StOff;
            lockout_d = 1'b1;
          end else begin
            state_d = StDisarming;
          end
        end else if (auto_off) begin
          state_d   = StOff;
          lockout_d = 1'b0;
        end else begin
          state_d = StOn;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk_ms or negedge rst) begin
    if (!rst) begin
      state_q   <= StOff;
      lockout_q <= 1'b0;
      power_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lockout_q <= lockout_d;
      power_q   <= is_live(state_d);
    end
  end

  assign bus.power    = power_q;
  assign bus.state    = state_q;
  assign bus.arm_busy = (state_q == StArming);

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl; covers the auto-off path when
// POWER_SEQ_AUTO_OFF_EN is defined, otherwise checks it stays inert.
module tb_power_seq_ctrl;

  logic clk_ms = 1'b0;
  logic rst    = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  power_seq_ctrl_if pwr ();

  power_seq_ctrl #(
    .HOLD_MS     (5),
    .OFF_HOLD_MS (3),
    .IDLE_MS     (8),
    .WARN_MS     (3),
    .CNT_W       (4)
  ) dut (
    .clk_ms (clk_ms),
    .rst    (rst),
    .bus    (pwr)
  );

  always #5 clk_ms = ~clk_ms;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ms);
    #1;
  endtask

  task automatic check_sp(input string tag, input int st, input int pw);
    check_eq({tag, ".state"}, 32'(pwr.state), 32'(st));
    check_eq({tag, ".power"}, 32'(pwr.power), 32'(pw));
  endtask

  initial begin
    pwr.on_btn   = 1'b0;
    pwr.off_btn  = 1'b0;
    pwr.activity = 1'b1;
    tick(1);
    check_sp("reset", 0, 0);
    check_eq("reset.arm_busy", 32'(pwr.arm_busy), 0);
    check_eq("reset.idle_warn", 32'(pwr.idle_warn), 0);
    check_eq("reset.timeout", 32'(pwr.timeout_pulse), 0);
    #2 rst = 1'b1;

    // Hold on_btn for 5 edges.
    pwr.on_btn = 1'b1;
    tick(1);
    check_sp("arm1", 1, 0);
    check_eq("arm1.arm_busy", 32'(pwr.arm_busy), 1);
    tick(3);
    check_sp("arm4", 1, 0);
    tick(1);
    check_sp("on5", 2, 1);
    check_eq("on5.arm_busy", 32'(pwr.arm_busy), 0);

    // Short off press returns to ON.
    pwr.on_btn  = 1'b0;
    pwr.off_btn = 1'b1;
    tick(2);
    check_sp("dis2", 3, 1);
    pwr.off_btn = 1'b0;
    tick(1);
    check_sp("dis_back", 2, 1);

    // Full off press with on_btn held: lockout blocks re-arm.
    pwr.on_btn  = 1'b1;
    pwr.off_btn = 1'b1;
    tick(2);
    check_sp("off2", 3, 1);
    tick(1);
    check_sp("off3", 0, 0);
    pwr.off_btn = 1'b0;
    tick(10);
    check_sp("lockout", 0, 0);
    pwr.on_btn = 1'b0;
    tick(1);
    pwr.on_btn = 1'b1;
    tick(4);
    check_sp("rearm4", 1, 0);
    tick(1);
    check_sp("rearm5", 2, 1);
    pwr.on_btn  = 1'b0;
    pwr.off_btn = 1'b1;
    tick(3);
    check_sp("off_a", 0, 0);
    pwr.off_btn = 1'b0;
    tick(1);

    // Abort after 4 edges; next press restarts from 1.
    pwr.on_btn = 1'b1;
    tick(4);
    check_sp("abort_pre", 1, 0);
    pwr.on_btn = 1'b0;
    tick(1);
    check_sp("abort", 0, 0);
    pwr.on_btn = 1'b1;
    tick(4);
    check_sp("restart4", 1, 0);
    tick(1);
    check_sp("restart5", 2, 1);
    pwr.on_btn  = 1'b0;
    pwr.off_btn = 1'b1;
    tick(3);
    check_sp("off_b", 0, 0);
    pwr.off_btn = 1'b0;
    tick(1);

    // Both buttons from OFF, then off pulse aborts ARMING.
    pwr.on_btn  = 1'b1;
    pwr.off_btn = 1'b1;
    tick(10);
    check_sp("both", 0, 0);
    pwr.off_btn = 1'b0;
    tick(1);
    check_sp("both_arm", 1, 0);
    pwr.off_btn = 1'b1;
    tick(1);
    check_sp("off_abort", 0, 0);
    pwr.off_btn = 1'b0;
    pwr.on_btn  = 1'b0;
    tick(1);

    // Async reset mid-ARMING.
    pwr.on_btn = 1'b1;
    tick(2);
    check_sp("rst_arm_pre", 1, 0);
    #2 rst = 1'b0;
    #1;
    check_sp("rst_arm", 0, 0);
    check_eq("rst_arm.arm_busy", 32'(pwr.arm_busy), 0);
    rst = 1'b1;
    tick(4);
    check_sp("rst_arm4", 1, 0);
    tick(1);
    check_sp("rst_arm5", 2, 1);

    // Async reset mid-ON with an off press in progress.
    pwr.on_btn  = 1'b0;
    pwr.off_btn = 1'b1;
    tick(1);
    check_sp("rst_on_pre", 3, 1);
    #2 rst = 1'b0;
    #1;
    check_sp("rst_on", 0, 0);
    rst         = 1'b1;
    pwr.off_btn = 1'b0;
    pwr.on_btn  = 1'b1;
    tick(5);
    check_sp("rst_on_rearm", 2, 1);
    pwr.on_btn  = 1'b0;
    pwr.off_btn = 1'b1;
    tick(2);
    check_sp("rst_on_dis2", 3, 1);
    tick(1);
    check_sp("rst_on_off3", 0, 0);
    pwr.off_btn = 1'b0;
    tick(1);

`ifdef POWER_SEQ_AUTO_OFF_EN
    pwr.on_btn = 1'b1;
    tick(5);
    check_sp("ao_on", 2, 1);
    pwr.on_btn   = 1'b0;
    pwr.activity = 1'b0;
    tick(4);
    check_eq("warn_idle4", 32'(pwr.idle_warn), 0);
    tick(1);
    check_eq("warn_idle5", 32'(pwr.idle_warn), 1);
    pwr.activity = 1'b1;
    tick(1);
    check_eq("warn_cleared", 32'(pwr.idle_warn), 0);
    check_sp("act_pulse", 2, 1);
    pwr.activity = 1'b0;
    tick(7);
    check_sp("idle7", 2, 1);
    check_eq("idle7.warn", 32'(pwr.idle_warn), 1);
    check_eq("idle7.timeout", 32'(pwr.timeout_pulse), 0);
    tick(1);
    check_sp("idle8", 0, 0);
    check_eq("idle8.timeout", 32'(pwr.timeout_pulse), 1);
    check_eq("idle8.warn", 32'(pwr.idle_warn), 0);
    tick(1);
    check_eq("timeout_once", 32'(pwr.timeout_pulse), 0);
    pwr.on_btn = 1'b1;
    tick(1);
    check_sp("ao_no_lock", 1, 0);
    tick(4);
    check_sp("ao_on2", 2, 1);
    pwr.on_btn = 1'b0;
    tick(7);
    check_eq("race.warn", 32'(pwr.idle_warn), 1);
    pwr.off_btn = 1'b1;
    tick(1);
    check_sp("race", 3, 1);
    check_eq("race.timeout", 32'(pwr.timeout_pulse), 0);
    tick(2);
    check_sp("race_off", 0, 0);
    check_eq("race_off.timeout", 32'(pwr.timeout_pulse), 0);
    pwr.off_btn = 1'b0;
`else
    pwr.on_btn = 1'b1;
    tick(5);
    check_sp("noao_on", 2, 1);
    pwr.on_btn   = 1'b0;
    pwr.activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_eq("noao.power", 32'(pwr.power), 1);
      check_eq("noao.warn", 32'(pwr.idle_warn), 0);
      check_eq("noao.timeout", 32'(pwr.timeout_pulse), 0);
    end
    pwr.off_btn = 1'b1;
    tick(3);
    check_sp("noao_off", 0, 0);
    pwr.off_btn = 1'b0;
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
